// File: rtl/intt_addr_seq_if.sv
// rtl/intt_addr_seq_if.sv - handshake and address bundle between the INTT sequencer and the butterfly unit
interface intt_addr_seq_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_idx1;
    logic [ADDR_W-1:0] rd_idx2;
    logic [ADDR_W-1:0] tw_idx;
    logic              rd_scale;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_idx1;
    logic [ADDR_W-1:0] wr_idx2;

    modport master (
        input  start, rd_ready,
        output busy, done, rd_valid, rd_idx1, rd_idx2, tw_idx, rd_scale,
               wr_valid, wr_idx1, wr_idx2
    );

    modport slave (
        output start, rd_ready,
        input  busy, done, rd_valid, rd_idx1, rd_idx2, tw_idx, rd_scale,
               wr_valid, wr_idx1, wr_idx2
    );
endinterface

// File: rtl/intt_addr_seq.sv
// rtl/intt_addr_seq.sv - inverse NTT (Gentleman-Sande) read/twiddle/write-back address sequencer
// Optional final N^-1 scaling pass is enabled by defining INTT_SCALE_EN.
module intt_addr_seq #(
    parameter int N      = 8,
    parameter int ADDR_W = 5,
    parameter int BF_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    intt_addr_seq_if.master  bus
);
    localparam int LOG_N = $clog2(N);
    localparam int SW    = 3;

`ifdef INTT_SCALE_EN
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SCALE, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
`endif

    state_t            state;
    logic [SW-1:0]     s;
    logic [ADDR_W-1:0] k;
    logic              busy;
    logic              done;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_idx1;
    logic [ADDR_W-1:0] rd_idx2;
    logic [ADDR_W-1:0] tw_idx;
    logic [BF_LAT-1:0] pipe_v;
    logic [ADDR_W-1:0] pipe_i1 [BF_LAT];
    logic [ADDR_W-1:0] pipe_i2 [BF_LAT];
    logic              pipe_busy;
    logic              accept;
`ifdef INTT_SCALE_EN
    logic              rd_scale;
    logic              scale_phase;
`endif

    // Upper-wing index: butterfly group (k/t) spans 2t entries, offset k mod t inside it.
    function automatic logic [ADDR_W-1:0] idx1_of(input logic [SW-1:0] st, input logic [ADDR_W-1:0] kk);
        logic [ADDR_W-1:0] lo;
        logic [ADDR_W-1:0] hi;
        lo = kk & ((ADDR_W'(1) << st) - ADDR_W'(1));
        hi = (kk >> st) << (st + SW'(1));
        return hi | lo;
    endfunction

    function automatic logic [ADDR_W-1:0] tw_of(input logic [SW-1:0] st, input logic [ADDR_W-1:0] kk);
        logic [ADDR_W-1:0] lo;
        lo = kk & ((ADDR_W'(1) << st) - ADDR_W'(1));
        return lo << (LOG_N - 1 - int'(st));
    endfunction

    assign accept = rd_valid & bus.rd_ready;

    // Only entries behind the output slot still have to land before the next stage may read.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < BF_LAT - 1; i++) begin
            pipe_busy = pipe_busy | pipe_v[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= '0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_idx1  <= '0;
            rd_idx2  <= '0;
            tw_idx   <= '0;
            pipe_v   <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_i1[i] <= '0;
                pipe_i2[i] <= '0;
            end
`ifdef INTT_SCALE_EN
            rd_scale    <= 1'b0;
            scale_phase <= 1'b0;
`endif
        end else begin
            for (int i = BF_LAT - 1; i > 0; i--) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_i1[i] <= pipe_i1[i-1];
                pipe_i2[i] <= pipe_i2[i-1];
            end
            pipe_v[0]  <= accept;
            pipe_i1[0] <= accept ? rd_idx1 : '0;
            pipe_i2[0] <= accept ? rd_idx2 : '0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= ISSUE;
                        s        <= '0;
                        k        <= '0;
                        busy     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_idx1  <= '0;
                        rd_idx2  <= ADDR_W'(1);
                        tw_idx   <= '0;
`ifdef INTT_SCALE_EN
                        scale_phase <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (k == ADDR_W'(N/2 - 1)) begin
                            state    <= DRAIN;
                            rd_valid <= 1'b0;
                        end else begin
                            k       <= k + ADDR_W'(1);
                            rd_idx1 <= idx1_of(s, k + ADDR_W'(1));
                            rd_idx2 <= idx1_of(s, k + ADDR_W'(1)) + (ADDR_W'(1) << s);
                            tw_idx  <= tw_of(s, k + ADDR_W'(1));
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
`ifdef INTT_SCALE_EN
                        if (scale_phase) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else
`endif
                        if (s < SW'(LOG_N - 1)) begin
                            state    <= ISSUE;
                            s        <= s + SW'(1);
                            k        <= '0;
                            rd_valid <= 1'b1;
                            rd_idx1  <= '0;
                            rd_idx2  <= ADDR_W'(1) << (s + SW'(1));
                            tw_idx   <= '0;
                        end else begin
`ifdef INTT_SCALE_EN
                            state    <= SCALE;
                            k        <= '0;
                            rd_valid <= 1'b1;
                            rd_scale <= 1'b1;
                            rd_idx1  <= '0;
                            rd_idx2  <= '0;
                            tw_idx   <= '0;
`else
                            state <= DONE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef INTT_SCALE_EN
                SCALE: begin
                    if (accept) begin
                        if (k == ADDR_W'(N - 1)) begin
                            state       <= DRAIN;
                            rd_valid    <= 1'b0;
                            rd_scale    <= 1'b0;
                            scale_phase <= 1'b1;
                        end else begin
                            k       <= k + ADDR_W'(1);
                            rd_idx1 <= k + ADDR_W'(1);
                            rd_idx2 <= k + ADDR_W'(1);
                        end
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_idx1  = rd_idx1;
    assign bus.rd_idx2  = rd_idx2;
    assign bus.tw_idx   = tw_idx;
    assign bus.wr_valid = pipe_v[BF_LAT-1];
    assign bus.wr_idx1  = pipe_i1[BF_LAT-1];
    assign bus.wr_idx2  = pipe_i2[BF_LAT-1];
`ifdef INTT_SCALE_EN
    assign bus.rd_scale = rd_scale;
`else
    assign bus.rd_scale = 1'b0;
`endif
endmodule

// File: tb/tb_intt_addr_seq.sv
// tb/tb_intt_addr_seq.sv - table-driven directed bench for intt_addr_seq (N=8, BF_LAT=3)
module tb_intt_addr_seq;
    localparam int N      = 8;
    localparam int ADDR_W = 5;
    localparam int BF_LAT = 3;
`ifdef INTT_SCALE_EN
    localparam int NVEC     = 20;
    localparam int DONE_CYC = 33;
`else
    localparam int NVEC     = 12;
    localparam int DONE_CYC = 22;
`endif

    typedef struct {
        int                stage;
        logic [ADDR_W-1:0] i1;
        logic [ADDR_W-1:0] i2;
        logic [ADDR_W-1:0] tw;
        logic              sc;
    } rd_vec_t;

    rd_vec_t tbl [NVEC];
    int      vec_cnt = 0;
    int      err_cnt = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    intt_addr_seq_if #(.ADDR_W(ADDR_W)) bus ();

    intt_addr_seq #(.N(N), .ADDR_W(ADDR_W), .BF_LAT(BF_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input int st, input int a, input int b, input int t, input int sc);
        tbl[i].stage = st;
        tbl[i].i1    = ADDR_W'(a);
        tbl[i].i2    = ADDR_W'(b);
        tbl[i].tw    = ADDR_W'(t);
        tbl[i].sc    = sc[0];
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},     int'(bus.busy),     0);
        chk({tag, "_done"},     int'(bus.done),     0);
        chk({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
        chk({tag, "_rd_idx1"},  int'(bus.rd_idx1),  0);
        chk({tag, "_rd_idx2"},  int'(bus.rd_idx2),  0);
        chk({tag, "_tw_idx"},   int'(bus.tw_idx),   0);
        chk({tag, "_rd_scale"}, int'(bus.rd_scale), 0);
        chk({tag, "_wr_valid"}, int'(bus.wr_valid), 0);
        chk({tag, "_wr_idx1"},  int'(bus.wr_idx1),  0);
        chk({tag, "_wr_idx2"},  int'(bus.wr_idx2),  0);
    endtask

    // Cycle 0 is the cycle whose closing edge samples start; observations happen at negedges.
    task automatic run_tf(input int stall_n, input int stall_len, input int rst_cyc);
        int                cyc        = 0;
        int                n          = 0;
        int                stall_left = stall_len;
        int                done_cyc   = DONE_CYC + stall_len;
        int                q_cyc[$];
        int                q_stg[$];
        logic [ADDR_W-1:0] q_i1[$];
        logic [ADDR_W-1:0] q_i2[$];
        bit                finished   = 1'b0;
        bit                barrier_hit;
        int                c0;
        logic [ADDR_W-1:0] e1;
        logic [ADDR_W-1:0] e2;

        @(negedge clk);
        bus.start    = 1'b1;
        bus.rd_ready = 1'b1;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_zero("mid_reset");
                repeat (2) @(negedge clk);
                rst_n        = 1'b1;
                bus.rd_ready = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("post_reset_wr_valid", int'(bus.wr_valid), 0);
                    chk("post_reset_busy",     int'(bus.busy),     0);
                end
                finished = 1'b1;
            end else begin
                chk("busy_running", int'(bus.busy), 1);
                if (bus.rd_valid) begin
                    chk("read_in_range", int'(n < NVEC), 1);
                    if (n < NVEC) begin
                        chk("rd_idx1",  int'(bus.rd_idx1),  int'(tbl[n].i1));
                        chk("rd_idx2",  int'(bus.rd_idx2),  int'(tbl[n].i2));
                        chk("tw_idx",   int'(bus.tw_idx),   int'(tbl[n].tw));
                        chk("rd_scale", int'(bus.rd_scale), int'(tbl[n].sc));
                        barrier_hit = 1'b0;
                        foreach (q_stg[j]) if (q_stg[j] < tbl[n].stage) barrier_hit = 1'b1;
                        chk("stage_barrier", int'(barrier_hit), 0);
                    end
                end
                if (bus.rd_valid && n == stall_n && stall_left > 0) begin
                    bus.rd_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.rd_ready = 1'b1;
                end
                if (bus.wr_valid) begin
                    chk("wr_expected", int'(q_cyc.size() > 0), 1);
                    if (q_cyc.size() > 0) begin
                        c0 = q_cyc.pop_front();
                        e1 = q_i1.pop_front();
                        e2 = q_i2.pop_front();
                        void'(q_stg.pop_front());
                        chk("wr_latency", cyc - c0, BF_LAT);
                        chk("wr_idx1", int'(bus.wr_idx1), int'(e1));
                        chk("wr_idx2", int'(bus.wr_idx2), int'(e2));
                    end
                end
                if (bus.rd_valid && bus.rd_ready && n < NVEC) begin
                    q_cyc.push_back(cyc);
                    q_stg.push_back(tbl[n].stage);
                    q_i1.push_back(bus.rd_idx1);
                    q_i2.push_back(bus.rd_idx2);
                    n++;
                end
                if (bus.done) begin
                    chk("done_cycle", cyc, done_cyc);
                    chk("all_reads",  n,   NVEC);
                    chk("pipe_empty", q_cyc.size(), 0);
                    @(negedge clk);
                    chk("idle_busy", int'(bus.busy), 0);
                    chk("idle_done", int'(bus.done), 0);
                    chk("idle_rd_valid", int'(bus.rd_valid), 0);
                    finished = 1'b1;
                end
            end
        end
        if (!finished) chk("timeout", 0, 1);
    endtask

    initial begin
        set_vec(0,  0, 0, 1, 0, 0);
        set_vec(1,  0, 2, 3, 0, 0);
        set_vec(2,  0, 4, 5, 0, 0);
        set_vec(3,  0, 6, 7, 0, 0);
        set_vec(4,  1, 0, 2, 0, 0);
        set_vec(5,  1, 1, 3, 2, 0);
        set_vec(6,  1, 4, 6, 0, 0);
        set_vec(7,  1, 5, 7, 2, 0);
        set_vec(8,  2, 0, 4, 0, 0);
        set_vec(9,  2, 1, 5, 1, 0);
        set_vec(10, 2, 2, 6, 2, 0);
        set_vec(11, 2, 3, 7, 3, 0);
`ifdef INTT_SCALE_EN
        for (int e = 0; e < N; e++) set_vec(12 + e, 3, e, e, 0, 1);
`endif

        bus.start    = 1'b0;
        bus.rd_ready = 1'b0;
        rst_n        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start    = 1'($urandom_range(0, 1));
            bus.rd_ready = 1'($urandom_range(0, 1));
            #1;
            check_zero("reset");
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rd_ready = 1'b1;
        rst_n        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_start_busy",     int'(bus.busy),     0);
            chk("idle_no_start_rd_valid", int'(bus.rd_valid), 0);
        end

        run_tf(-1, 0, -1);
        run_tf(5, 5, -1);
        run_tf(-1, 0, 10);
        run_tf(-1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/intt_addr_seq.md
# intt_addr_seq

Address and twiddle sequencer for the inverse NTT (Gentleman-Sande) pass of the 8-point NTT processor. It walks stages from half-span t=1 up to t=N/2 and issues one butterfly read-address pair plus a twiddle exponent per handshake. It also issues the matching write-back address pair exactly BF_LAT cycles later. Between stages it drains the write-back pipeline so that no read of stage s+1 overtakes a write of stage s.

## Interface
- N, 8: transform size; power of two, 4..32.
- ADDR_W, 5: width of index and twiddle buses.
- BF_LAT, 3: butterfly latency in cycles, accept-to-write-back; 1..8.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- rd_valid  out  1  read pair/twiddle valid.
- rd_ready  in  1  butterfly unit accepts the pair.
- rd_idx1  out  ADDR_W  upper-wing read index.
- rd_idx2  out  ADDR_W  lower-wing read index.
- tw_idx  out  ADDR_W  inverse-root exponent for this butterfly.
- rd_scale  out  1  scale-pass marker (see Configuration).
- wr_valid  out  1  write-back pair valid; no backpressure.
- wr_idx1  out  ADDR_W  write-back index 1.
- wr_idx2  out  ADDR_W  write-back index 2.

## Operation
- States: IDLE, ISSUE, DRAIN, SCALE (only with the macro), DONE.
- IDLE:
  - start=1 -> ISSUE, with stage s=0 and butterfly counter k=0.
  - start is ignored in all other states.
- ISSUE:
  - t = 1<<s.
  - rd_idx1 = (k/t)*2t + (k mod t).
  - rd_idx2 = rd_idx1 + t.
  - tw_idx = (k mod t)*(N/(2t)).
  - rd_valid=1 for the whole state.
  - Outputs hold stable while rd_valid=1 and rd_ready=0.
  - On an accept (rd_valid & rd_ready), k increments.
  - On acceptance of k=N/2-1, go to DRAIN.
- Write-back pipeline:
  - BF_LAT-deep shift register of {valid, idx1, idx2}.
  - Advances every cycle.
  - Loaded with the accepted pair, otherwise with a bubble.
- DRAIN:
  - rd_valid=0.
  - Leave when no entry remains behind the one currently at the pipeline output.
  - Exit target: if s < log2(N)-1, set s=s+1, k=0 and go to ISSUE. Otherwise go to SCALE if the macro is defined, else DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - All indexes are unsigned, less than N, zero-extended to ADDR_W.
  - No wrap-around is possible for legal N.
- Reset values: state=IDLE, s=k=0, and every output 0, including the pipeline valids and indexes.
- Reset mid-operation: the pipeline is flushed and no further wr_valid appears. After rst_n rises, the block waits for a fresh start.

## Timing
- Cycle 0 is the cycle in which start is sampled in IDLE. The first rd_valid is in cycle 1.
- wr_valid for a pair accepted in cycle c is in cycle c+BF_LAT.
- With rd_ready held at 1, each stage takes N/2+BF_LAT cycles.
- N=8, BF_LAT=3:
  - ISSUE starts in cycles 1, 8 and 15.
  - Last wr_valid in cycle 21.
  - done in cycle 22.
  - busy low from cycle 23.
- rd_ready may toggle arbitrarily. Stalls delay issue but never reorder it.

## Configuration
- INTT_SCALE_EN defined:
  - After the final DRAIN, SCALE issues N single-element reads with rd_idx1=rd_idx2=e for e=0..N-1, tw_idx=0 and rd_scale=1.
  - These are written back through the same pipeline, one write per element, for multiplication by N^-1.
  - SCALE then drains the pipeline and goes to DONE.
- INTT_SCALE_EN undefined:
  - No SCALE state exists.
  - rd_scale is tied to 0.
  - The final DRAIN goes directly to DONE.

## Test plan
- Reset check: rst_n low with random inputs -> every output 0. After release, start=0 -> stays IDLE with busy=0.
- N=8, rd_ready=1, start pulse:
  - read pairs in order (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0;
  - then (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2;
  - then (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3;
  - done in cycle 22.
- rd_ready low for 5 cycles while (1,3) is pending -> rd_idx1=1, rd_idx2=3 and tw_idx=2 held stable throughout; each wr_valid is exactly 3 cycles after its accept.
- Stage barrier: the first read of stage 1 occurs only after the wr_valid for (6,7). No rd_valid in any cycle where that write is still in flight.
- rst_n asserted in cycle 10 mid-stage -> all outputs 0 immediately and no later wr_valid. A new start completes a full, correct sequence.
- With INTT_SCALE_EN: after stage 2, reads (e,e) for e=0..7 with rd_scale=1 and matching writes; done in cycle 33.
